// File: rtl/led_sequencer.sv
// LED animation engine: OFF/STATIC/FILL/CHASE/BOUNCE/BLINK frames stepped by a prescaler, gated by global PWM.
// Latency: leds is registered and lags the internal frame and PWM gate by one clock; step_tick is decoded from the prescaler.
// Backpressure: none; mode_load is accepted every cycle and always restarts the animation.
module led_sequencer #(
  parameter int          WIDTH        = 8,
  parameter int          TICK_DIV     = 2_000_000,
  parameter int          PWM_BITS     = 4,
  parameter logic [2:0]  STARTUP_MODE = 3'd2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [2:0]          mode,
  input  logic [WIDTH-1:0]    pattern,
  input  logic                mode_load,
  input  logic [PWM_BITS-1:0] brightness,
  output logic [WIDTH-1:0]    leds,
  output logic                step_tick
);

  localparam int              PW        = $clog2(TICK_DIV);
  localparam logic [PW-1:0]   TICK_LAST = PW'(TICK_DIV - 1);

  localparam logic [2:0] M_OFF    = 3'd0;
  localparam logic [2:0] M_STATIC = 3'd1;
  localparam logic [2:0] M_FILL   = 3'd2;
  localparam logic [2:0] M_CHASE  = 3'd3;
  localparam logic [2:0] M_BOUNCE = 3'd4;
  localparam logic [2:0] M_BLINK  = 3'd5;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [PW-1:0]       r_presc;
  logic [WIDTH-1:0]    r_frame;
  logic                r_dir_left;
  logic [2:0]          r_mode;
  logic [WIDTH-1:0]    r_pattern;
  logic [PWM_BITS-1:0] r_pwm_cnt;

  logic                w_tick;
  logic                w_onehot;
  logic                w_gate;
  logic                w_go_left;
  logic [WIDTH-1:0]    w_shift;
  logic [WIDTH-1:0]    w_step_frame;
  logic                w_step_dir_left;

  // Frame shown immediately after a load; unknown/reserved modes start dark.
  function automatic logic [WIDTH-1:0] init_frame(input logic [2:0] m, input logic [WIDTH-1:0] p);
    case (m)
      M_STATIC, M_BLINK: init_frame = p;
      M_CHASE, M_BOUNCE: init_frame = ONE;
      default:           init_frame = '0;
    endcase
  endfunction

  assign w_tick    = (r_presc == TICK_LAST);
  assign step_tick = w_tick;
  assign w_onehot  = (r_frame != '0) && ((r_frame & (r_frame - ONE)) == '0);
  // All-ones brightness must be fully on even though pwm_cnt never exceeds it.
  assign w_gate    = (r_pwm_cnt < brightness) || (&brightness);

  // Next frame and bounce direction for the current mode, applied only on a step.
  always_comb begin
    w_step_frame    = '0;
    w_step_dir_left = r_dir_left;
    w_go_left       = 1'b1;
    w_shift         = '0;
    case (r_mode)
      M_STATIC: w_step_frame = r_pattern;
      M_FILL:   w_step_frame = (&r_frame) ? '0 : ((r_frame << 1) | ONE);
      M_CHASE: begin
        if (!w_onehot) w_step_frame = ONE;
        else           w_step_frame = (r_frame << 1) | (r_frame >> (WIDTH - 1));
      end
      M_BOUNCE: begin
        if (!w_onehot || (WIDTH == 1)) begin
          w_step_frame    = ONE;
          w_step_dir_left = 1'b1;
        end else begin
          // An end bit forces the turn even if direction and position disagree.
          w_go_left = r_dir_left ? !r_frame[WIDTH-1] : r_frame[0];
          if (w_go_left) begin
            w_shift         = r_frame << 1;
            w_step_dir_left = !w_shift[WIDTH-1];
          end else begin
            w_shift         = r_frame >> 1;
            w_step_dir_left = w_shift[0];
          end
          w_step_frame = w_shift;
        end
      end
      M_BLINK:  w_step_frame = (r_frame != '0) ? '0 : r_pattern;
      default:  w_step_frame = '0;
    endcase
  end

  // Prescaler, mode/pattern latch and frame state; a load wins over a coincident step.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_presc    <= '0;
      r_frame    <= '0;
      r_dir_left <= 1'b1;
      r_mode     <= STARTUP_MODE;
      r_pattern  <= '0;
    end else if (mode_load) begin
      r_presc    <= '0;
      r_mode     <= mode;
      r_pattern  <= pattern;
      r_frame    <= init_frame(mode, pattern);
      r_dir_left <= 1'b1;
    end else begin
      r_presc <= w_tick ? '0 : (r_presc + PW'(1));
      if (w_tick) begin
        r_frame    <= w_step_frame;
        r_dir_left <= w_step_dir_left;
      end
    end
  end

  // Free-running PWM phase counter, independent of mode loads.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_pwm_cnt <= '0;
    else       r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
  end

  // Registered LED drive: frame gated by the PWM duty.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) leds <= '0;
    else       leds <= r_frame & {WIDTH{w_gate}};
  end

endmodule

// File: doc/led_sequencer.md
Name: led_sequencer

Overview:
- Parametrised LED animation engine driving the board LED bank.
- Generalises the fixed 8-LED power-on fill into selectable modes, configurable width and step rate, plus global PWM brightness.
- Sits between the system clock domain and the LED pins; mode and pattern are loaded from control logic via a one-cycle strobe.

Parameters:
WIDTH, 8, number of LEDs (>=1)
TICK_DIV, 2_000_000, clock cycles per animation step (>=2)
PWM_BITS, 4, brightness resolution in bits (>=1)
STARTUP_MODE, 2, mode active after reset (2 = FILL)

Ports:
clock  input  1  system clock; all state on rising edge
reset  input  1  asynchronous, active-high reset
mode  input  3  requested mode, sampled when mode_load=1
pattern  input  WIDTH  pattern for STATIC/BLINK, sampled when mode_load=1
mode_load  input  1  one-cycle strobe: latch mode and pattern, restart animation
brightness  input  PWM_BITS  global duty, sampled live every cycle
leds  output  WIDTH  registered LED drive, active-high
step_tick  output  1  one-cycle pulse on each animation step

Behaviour:
- Reset (async, active-high): leds=0, frame=0, prescaler=0, pwm_cnt=0, step_tick=0, direction=left, mode_reg=STARTUP_MODE, pattern_reg=0. Outputs stay at these values while reset is high. Reset mid-animation abandons the sequence. Restart after release is the STARTUP_MODE initial frame.
- Prescaler counts 0..TICK_DIV-1 and wraps. step_tick=1 for exactly the cycle in which prescaler==TICK_DIV-1. frame advances on that same edge.
- Modes (mode_reg):
  - 0 OFF: frame=0.
  - 1 STATIC: frame=pattern_reg, no stepping.
  - 2 FILL: each step, frame=(frame<<1)|1. The step after frame is all-ones, frame=0. Period WIDTH+1 steps, repeats forever.
  - 3 CHASE: one-hot rotate left; MSB wraps to LSB. Period WIDTH steps.
  - 4 BOUNCE: one-hot shifts in direction. At MSB, direction flips to right; at LSB, flips to left. The flip happens on the step that reaches the end bit, so an end bit is lit for one step only. Period 2*(WIDTH-1) steps. WIDTH=1: frame stays 1.
  - 5 BLINK: frame alternates pattern_reg, 0, pattern_reg, ...
  - 6, 7: reserved, behave as OFF.
- Initial frame, at reset or load: OFF 0; STATIC pattern; FILL 0; CHASE 1; BOUNCE 1 with direction=left; BLINK pattern.
- Any non-one-hot frame in CHASE/BOUNCE is forced to 1 on the next step.
- mode_load=1 at edge N: mode_reg, pattern_reg and the initial frame are loaded, prescaler=0, step_tick=0 at N. The first step follows TICK_DIV cycles later. mode_load has priority over a coincident tick; that tick is dropped. Back-to-back loads: the last one wins, and each restarts the prescaler.
- PWM: pwm_cnt is a free-running PWM_BITS counter, wrapping at all-ones.
  - gate=1 when pwm_cnt < brightness, or when brightness is all-ones.
  - brightness=0 means always dark; all-ones means always on.
- leds = frame & {WIDTH{gate}}, registered. leds lags frame and gate by one clock.
- Widths: prescaler width is clog2(TICK_DIV), with no overflow beyond TICK_DIV-1. All shifts are truncated to WIDTH.

Test Plan:
(Bench parameters: WIDTH=4, TICK_DIV=4, PWM_BITS=2, brightness=3, unless stated.)
- Reset, then release with STARTUP_MODE=2 -> leds steps 0000,0001,0011,0111,1111,0000,... Each value holds 4 clocks. step_tick pulses every 4 clocks.
- Load mode=4 -> leds 0001,0010,0100,1000,0100,0010,0001,0010. Period 6 steps; no end value repeats.
- Load mode=5 with pattern=1010, then load mode=3 one cycle before a tick -> that tick is suppressed. leds=0001 holds for the next 4 clocks, then 0010.
- brightness=1, mode=1, pattern=1111 -> leds=1111 for 1 of every 4 clocks. brightness=0 -> leds=0000 constantly. brightness=3 -> leds=1111 constantly.
- mode=6 loaded -> leds=0000 and no frame change, while step_tick still pulses every 4 clocks.
- Assert reset mid-CHASE, asynchronously between edges -> leds=0000 immediately. After release, the FILL sequence restarts from 0000.
